// File: rtl/sdm_pkg.sv
// Shared types and constants for the soft associative memory location logic.
package sdm_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} obuf_state_t;

  // Defaults kept in one place so the comparator and counter bank agree.
  localparam int DEF_DATA_WIDTH    = 512;
  localparam int DEF_COUNTER_WIDTH = 8;

  function automatic int SAT_MAX(input int cw);
    return (1 << (cw - 1)) - 1;
  endfunction

  function automatic int SAT_MIN(input int cw);
    return -(1 << (cw - 1));
  endfunction

endpackage

// File: rtl/sdm_sat_counter.sv
// One signed saturating up/down counter; sat pulses on a step that was clipped.
module sdm_sat_counter
  import sdm_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 up,
  output logic signed [CW-1:0] value,
  output logic                 sat
);

  localparam logic signed [CW-1:0] MAXV = CW'(SAT_MAX(CW));
  localparam logic signed [CW-1:0] MINV = CW'(SAT_MIN(CW));

  logic at_lim;

  assign at_lim = up ? (value == MAXV) : (value == MINV);
  // A cleared cycle discards the step, so it cannot clip either.
  assign sat    = en & ~clear & at_lim;

  // Counter state: clear beats a step; a step at the limit is dropped.
  always_ff @(posedge clk) begin
    if (rst)                 value <= '0;
    else if (clear)          value <= '0;
    else if (en && !at_lim)  value <= up ? value + CW'(1) : value - CW'(1);
  end

endmodule

// File: rtl/sdm_location_counters.sv
// Per-location counter bank: write hits step counters, read hits snapshot them
// into a single-entry ready/valid output buffer.
module sdm_location_counters
  import sdm_pkg::*;
#(
  parameter int DATA_WIDTH          = DEF_DATA_WIDTH,
  parameter int COUNTER_WIDTH       = DEF_COUNTER_WIDTH,
  parameter int NUM_PIPELINE_STAGES = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                valid,
  input  logic [DATA_WIDTH-1:0]               data,
  input  logic                                decisionReady,
  input  logic                                wnrDelayed,
  input  logic                                hit,
  input  logic                                clear,
  output logic                                readValid,
  input  logic                                readReady,
  output logic [DATA_WIDTH*COUNTER_WIDTH-1:0] readCounters,
  output logic                                dropped,
  output logic                                saturated
);

  logic [DATA_WIDTH-1:0]                    aligned;
  logic [DATA_WIDTH-1:0][COUNTER_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0]                    sat_vec;
  logic                                     write_hit, read_hit;
  obuf_state_t                              state, state_nxt;
  logic                                     load, drop;

  // Data delay line matching the comparator's decision latency.
  generate
    if (NUM_PIPELINE_STAGES == 0) begin : g_nodly
      assign aligned = data;
    end else begin : g_dly
      logic [NUM_PIPELINE_STAGES-1:0][DATA_WIDTH-1:0] data_pipe;
      // Shift every cycle; idle slots carry zero.
      always_ff @(posedge clk) begin
        if (rst) data_pipe <= '0;
        else begin
          data_pipe[0] <= valid ? data : '0;
          for (int s = 1; s < NUM_PIPELINE_STAGES; s++) data_pipe[s] <= data_pipe[s-1];
        end
      end
      assign aligned = data_pipe[NUM_PIPELINE_STAGES-1];
    end
  endgenerate

  assign write_hit = decisionReady & hit &  wnrDelayed;
  assign read_hit  = decisionReady & hit & ~wnrDelayed;

  generate
    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_cnt
      sdm_sat_counter #(.CW(COUNTER_WIDTH)) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .en    (write_hit),
        .up    (aligned[i]),
        .value (cnt[i]),
        .sat   (sat_vec[i])
      );
    end
  endgenerate

  // Output buffer state register.
  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Next state: load when empty or draining this cycle, otherwise a read hit is lost.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    drop      = 1'b0;
    case (state)
      EMPTY: if (read_hit) begin
        state_nxt = FULL;
        load      = 1'b1;
      end
      FULL: begin
        if (read_hit) begin
          if (readReady) load = 1'b1;
          else           drop = 1'b1;
        end else if (readReady) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Snapshot register and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      readCounters <= '0;
      dropped      <= 1'b0;
      saturated    <= 1'b0;
    end else begin
      if (load) readCounters <= cnt;
      dropped   <= dropped | drop;
      saturated <= saturated | (|sat_vec);
    end
  end

  assign readValid = (state == FULL);

endmodule

// File: tb/tb_sdm_location_counters.sv
// Randomized + directed bench with an array-based model of the counter bank.
module tb_sdm_location_counters;

  localparam int DW = 8, CW = 4, NPS = 2;

  logic          clk = 0, rst = 0, valid = 0, decisionReady = 0, wnrDelayed = 0, hit = 0;
  logic          clear = 0, readReady = 0, readValid, dropped, saturated;
  logic [DW-1:0] data = '0;
  logic [DW*CW-1:0] readCounters;

  int total = 0, bad = 0;

  sdm_location_counters #(.DATA_WIDTH(DW), .COUNTER_WIDTH(CW), .NUM_PIPELINE_STAGES(NPS)) dut (
    .clk(clk), .rst(rst), .valid(valid), .data(data), .decisionReady(decisionReady),
    .wnrDelayed(wnrDelayed), .hit(hit), .clear(clear), .readValid(readValid),
    .readReady(readReady), .readCounters(readCounters), .dropped(dropped), .saturated(saturated)
  );

  always #5 clk = ~clk;

  // Comparator emulation: request history, decisions emerge NPS cycles later.
  logic          hv[NPS], hw[NPS], hh[NPS], hg[NPS];
  logic [DW-1:0] hd[NPS];

  // Reference model of the location.
  int cnt[DW], snap[DW];
  bit m_valid, m_drop, m_sat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW*CW-1:0] pack_snap();
    logic [DW*CW-1:0] v;
    for (int i = 0; i < DW; i++) v[i*CW +: CW] = CW'(snap[i]);
    return v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".readValid"}, 32'(readValid), 32'(m_valid));
    chk({tag, ".dropped"},   32'(dropped),   32'(m_drop));
    chk({tag, ".saturated"}, 32'(saturated), 32'(m_sat));
    if (m_valid) chk({tag, ".readCounters"}, 32'(readCounters), 32'(pack_snap()));
  endtask

  task automatic model_reset();
    for (int i = 0; i < DW; i++) begin cnt[i] = 0; snap[i] = 0; end
    for (int s = 0; s < NPS; s++) begin hv[s] = 0; hw[s] = 0; hh[s] = 0; hg[s] = 0; hd[s] = '0; end
    m_valid = 0; m_drop = 0; m_sat = 0;
  endtask

  // One cycle: v/d/w/h/g describe a new request (g=0 suppresses its decision).
  task automatic step(input string tag, input logic v, input logic [DW-1:0] d, input logic w,
                      input logic h, input logic g, input logic rr, input logic clr);
    logic dr, wd, hd_, rh, wh;
    logic [DW-1:0] ad;
    @(negedge clk);
    dr = hv[NPS-1] & hg[NPS-1]; wd = hw[NPS-1]; hd_ = hh[NPS-1]; ad = hd[NPS-1];
    valid = v; data = d; readReady = rr; clear = clr;
    decisionReady = dr; wnrDelayed = wd; hit = hd_;
    for (int s = NPS - 1; s > 0; s--) begin
      hv[s] = hv[s-1]; hw[s] = hw[s-1]; hh[s] = hh[s-1]; hg[s] = hg[s-1]; hd[s] = hd[s-1];
    end
    hv[0] = v; hw[0] = w; hh[0] = h; hg[0] = g; hd[0] = d;
    rh = dr & hd_ & ~wd;
    wh = dr & hd_ & wd;
    // Snapshot sees counters before this cycle's write or clear.
    if (rh) begin
      if (!m_valid || rr) begin
        for (int i = 0; i < DW; i++) snap[i] = cnt[i];
        m_valid = 1;
      end else m_drop = 1;
    end else if (m_valid && rr) m_valid = 0;
    if (clr) begin
      for (int i = 0; i < DW; i++) cnt[i] = 0;
    end else if (wh) begin
      for (int i = 0; i < DW; i++) begin
        if (ad[i]) begin
          if (cnt[i] == 7) m_sat = 1; else cnt[i]++;
        end else begin
          if (cnt[i] == -8) m_sat = 1; else cnt[i]--;
        end
      end
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1; valid = 0; decisionReady = 0; hit = 0; wnrDelayed = 0; clear = 0; readReady = 0;
    @(posedge clk); #1;
    model_reset();
    chk({tag, ".readValid"},    32'(readValid), 32'd0);
    chk({tag, ".dropped"},      32'(dropped),   32'd0);
    chk({tag, ".saturated"},    32'(saturated), 32'd0);
    chk({tag, ".readCounters"}, 32'(readCounters), 32'd0);
    @(negedge clk); rst = 0;
  endtask

  task automatic idle(input string tag, input int n, input logic rr);
    for (int k = 0; k < n; k++) step(tag, 0, '0, 0, 0, 0, rr, 0);
  endtask

  initial begin
    model_reset();
    do_reset("reset");

    // Write then read; readValid appears NPS+1 cycles after the read's valid.
    step("wr_a5", 1, 8'hA5, 1, 1, 1, 0, 0);
    idle("wr_a5_flush", 2, 0);
    step("rd0", 1, '0, 0, 1, 1, 0, 0);
    idle("rd0_wait", 2, 0);
    chk("rd0_latency", 32'(readValid), 32'd1);
    idle("rd0_drain", 1, 1);

    // Positive saturation.
    for (int k = 0; k < 9; k++) step("wr_ff", 1, 8'hFF, 1, 1, 1, 1, 0);
    idle("ff_flush", 2, 1);
    step("rd_ff", 1, '0, 0, 1, 1, 1, 0);
    idle("rd_ff_wait", 2, 0);
    chk("rd_ff_all7", 32'(readCounters), 32'h7777_7777);
    idle("rd_ff_drain", 1, 1);

    // Clear, then negative saturation.
    step("clr", 0, '0, 0, 0, 0, 1, 1);
    for (int k = 0; k < 10; k++) step("wr_00", 1, 8'h00, 1, 1, 1, 1, 0);
    idle("00_flush", 2, 1);
    step("rd_00", 1, '0, 0, 1, 1, 0, 0);
    idle("rd_00_wait", 2, 0);
    chk("rd_00_all8", 32'(readCounters), 32'h8888_8888);
    idle("rd_00_drain", 1, 1);

    // Miss and suppressed decision leave counters alone.
    do_reset("reset2");
    step("wr_miss", 1, 8'h3C, 1, 0, 1, 1, 0);
    step("wr_nodr", 1, 8'hC3, 1, 1, 0, 1, 0);
    idle("miss_flush", 2, 1);
    chk("miss_no_valid", 32'(readValid), 32'd0);
    step("rd_miss", 1, '0, 0, 1, 1, 1, 0);
    idle("rd_miss_wait", 2, 0);
    chk("miss_zero", 32'(readCounters), 32'd0);

    // Backpressure: two reads while held, then a third with readReady.
    idle("bp_drain", 1, 1);
    step("bp_wr1", 1, 8'h0F, 1, 1, 1, 0, 0);
    step("bp_rd1", 1, '0, 0, 1, 1, 0, 0);
    step("bp_wr2", 1, 8'hF0, 1, 1, 1, 0, 0);
    step("bp_rd2", 1, '0, 0, 1, 1, 0, 0);
    step("bp_wr3", 1, 8'hF0, 1, 1, 1, 0, 0);
    step("bp_rd3", 1, '0, 0, 1, 1, 0, 0);
    step("bp_hold", 0, '0, 0, 0, 0, 0, 0);
    chk("bp_dropped", 32'(dropped), 32'd1);
    step("bp_b2b", 0, '0, 0, 0, 0, 1, 0);
    chk("bp_b2b_valid", 32'(readValid), 32'd1);
    idle("bp_drain2", 2, 1);

    // Clear coinciding with a write decision discards the write.
    step("cw_wr", 1, 8'hFF, 1, 1, 1, 1, 0);
    step("cw_gap", 0, '0, 0, 0, 0, 1, 0);
    step("cw_clr", 0, '0, 0, 0, 0, 1, 1);
    step("cw_rd", 1, '0, 0, 1, 1, 1, 0);
    idle("cw_wait", 2, 0);
    chk("cw_zero", 32'(readCounters), 32'd0);

    // Randomized traffic.
    for (int k = 0; k < 300; k++)
      step("rand", 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom_range(0, 15) == 0));

    // Reset while holding a snapshot.
    step("rf_rd", 1, '0, 0, 1, 1, 0, 0);
    idle("rf_wait", 2, 0);
    chk("rf_full", 32'(readValid), 32'd1);
    do_reset("reset_full");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
